// File: rtl/axi4_burst_writer.sv
// axi4_burst_writer
//    AXI4 write-master engine. It takes one command (start byte address and
//    beat count) plus a beat-wide data stream and issues legal AXI4 INCR
//    bursts on AW/W/B. Each burst is capped at MAX_BURST beats and never
//    crosses a 4 KB boundary. A credit counter limits the number of AW
//    transfers that are still waiting for a B response. One done pulse
//    reports each command.
//
// Ports
//    ACLK, ARESETN            clock, asynchronous active-low reset
//    cmd_valid/ready          command handshake
//    cmd_addr, cmd_len        start byte address (beat aligned internally), beat count
//    s_data/s_valid/s_ready   write data stream, passed straight through to W
//    done, done_err           one-cycle completion pulse, and its error status
//    busy                     a command is in progress
//    M_AXI_AW*                write address channel (INCR bursts only)
//    M_AXI_W*                 write data channel
//    M_AXI_B*                 write response channel
//
// FSM states
//    state   | meaning
//    IDLE    | cmd_ready high, waiting for a command
//    CALC    | size the next burst: min(remaining, MAX_BURST, beats left in 4 KB page)
//    AW      | present the burst address; AWVALID waits for a free credit
//    W       | stream blen beats from s_* to W, WLAST on the final beat
//    DRAIN   | all data sent, wait for the outstanding B responses, then pulse done
module axi4_burst_writer #(
   parameter int                ADDR_WIDTH      = 32,
   parameter int                DATA_WIDTH      = 64,
   parameter int                ID_WIDTH        = 1,
   parameter logic [ID_WIDTH-1:0] AXI_ID        = '0,
   parameter int                MAX_BURST       = 256,
   parameter int                MAX_OUTSTANDING = 4,
   parameter int                LEN_WIDTH       = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [LEN_WIDTH-1:0]    cmd_len,

   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic                    s_valid,
   output logic                    s_ready,

   output logic                    done,
   output logic                    done_err,
   output logic                    busy,

   output logic [ID_WIDTH-1:0]     M_AXI_AWID,
   output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [7:0]              M_AXI_AWLEN,
   output logic [2:0]              M_AXI_AWSIZE,
   output logic [1:0]              M_AXI_AWBURST,
   output logic                    M_AXI_AWLOCK,
   output logic [3:0]              M_AXI_AWCACHE,
   output logic [2:0]              M_AXI_AWPROT,
   output logic [3:0]              M_AXI_AWQOS,
   output logic                    M_AXI_AWVALID,
   input  logic                    M_AXI_AWREADY,

   output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                    M_AXI_WLAST,
   output logic                    M_AXI_WVALID,
   input  logic                    M_AXI_WREADY,

   input  logic [ID_WIDTH-1:0]     M_AXI_BID,
   input  logic [1:0]              M_AXI_BRESP,
   input  logic                    M_AXI_BVALID,
   output logic                    M_AXI_BREADY
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int LOG_B = $clog2(BYTES);
   localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
   // wide enough for the 13-bit page-room value and the command length
   localparam int RW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_AW,
      S_W,
      S_DRAIN
   } state_t;

   state_t                 state_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [LEN_WIDTH-1:0]   remaining_q;
   logic [8:0]             blen_q;
   logic [8:0]             beat_cnt_q;
   logic [OW-1:0]          outstanding_q;
   logic [OW-1:0]          outstanding_d;
   logic                   err_q;
   logic                   awvalid_q;
   logic [ADDR_WIDTH-1:0]  awaddr_q;
   logic [7:0]             awlen_q;
   logic                   cmd_ready_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   done_err_q;

   logic                   cmd_hs;
   logic                   aw_hs;
   logic                   w_hs;
   logic                   b_hs;
   logic                   bready;
   logic                   w_last;
   logic                   in_w;
   logic [12:0]            room_4k;
   logic [12:0]            beats_4k;
   logic [RW-1:0]          blen_lim;
   logic [8:0]             blen_d;
   logic [7:0]             awlen_d;
   logic [ADDR_WIDTH-1:0]  cmd_addr_al;

   // BID, BRESP[0] and the sub-beat address bits carry no information here
   logic                   unused_ok;
   assign unused_ok = ^{M_AXI_BID, M_AXI_BRESP[0], cmd_addr[LOG_B-1:0]};

   assign cmd_addr_al = {cmd_addr[ADDR_WIDTH-1:LOG_B], {LOG_B{1'b0}}};

   assign in_w   = (state_q == S_W);
   assign cmd_hs = cmd_valid & cmd_ready_q;
   assign aw_hs  = awvalid_q & M_AXI_AWREADY;
   assign w_hs   = in_w & s_valid & M_AXI_WREADY;
   assign bready = (outstanding_q != '0);
   assign b_hs   = M_AXI_BVALID & bready;
   assign w_last = (beat_cnt_q == 9'd1);

   // addr_q is always beat aligned, so the division by the beat size is exact
   assign room_4k  = 13'h1000 - {1'b0, addr_q[11:0]};
   assign beats_4k = room_4k >> LOG_B;

   always_comb begin
      blen_lim = RW'(MAX_BURST);
      if (RW'(beats_4k) < blen_lim) blen_lim = RW'(beats_4k);
      if (RW'(remaining_q) < blen_lim) blen_lim = RW'(remaining_q);
   end

   assign blen_d  = blen_lim[8:0];
   assign awlen_d = 8'(blen_d - 9'd1);

   // A same-cycle AW and B handshake cancel out. b_hs needs a nonzero
   // count, and AWVALID is only raised with a free credit, so the counter
   // cannot wrap in either direction.
   always_comb begin
      outstanding_d = outstanding_q;
      if (aw_hs && !b_hs)
         outstanding_d = outstanding_q + OW'(1);
      else if (!aw_hs && b_hs)
         outstanding_d = outstanding_q - OW'(1);
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         blen_q        <= '0;
         beat_cnt_q    <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         awvalid_q     <= 1'b0;
         awaddr_q      <= '0;
         awlen_q       <= '0;
         cmd_ready_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         done_err_q    <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         done_q        <= 1'b0;
         done_err_q    <= 1'b0;
         if (b_hs && M_AXI_BRESP[1])
            err_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_hs) begin
                  cmd_ready_q <= 1'b0;
                  addr_q      <= cmd_addr_al;
                  remaining_q <= cmd_len;
                  err_q       <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= (cmd_len == '0) ? S_DRAIN : S_CALC;
               end
            end

            S_CALC: begin
               awaddr_q <= addr_q;
               awlen_q  <= awlen_d;
               blen_q   <= blen_d;
               state_q  <= S_AW;
            end

            S_AW: begin
               if (awvalid_q) begin
                  if (M_AXI_AWREADY) begin
                     awvalid_q   <= 1'b0;
                     addr_q      <= addr_q + (ADDR_WIDTH'(blen_q) << LOG_B);
                     remaining_q <= remaining_q - LEN_WIDTH'(blen_q);
                     beat_cnt_q  <= blen_q;
                     state_q     <= S_W;
                  end
               end else if (outstanding_q < OW'(MAX_OUTSTANDING)) begin
                  awvalid_q <= 1'b1;
               end
            end

            S_W: begin
               if (w_hs) begin
                  beat_cnt_q <= beat_cnt_q - 9'd1;
                  if (w_last)
                     state_q <= (remaining_q != '0) ? S_CALC : S_DRAIN;
               end
            end

            S_DRAIN: begin
               // cmd_ready rises only in IDLE, so a new command lands at
               // the earliest on the cycle after done
               if (outstanding_q == '0) begin
                  done_q     <= 1'b1;
                  done_err_q <= err_q;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_err  = done_err_q;

   assign M_AXI_AWID    = AXI_ID;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWLEN   = awlen_q;
   assign M_AXI_AWSIZE  = 3'(LOG_B);
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWQOS   = 4'b0000;
   assign M_AXI_AWVALID = awvalid_q;

   // W is a straight pass-through of the data stream while in W
   assign s_ready      = in_w & M_AXI_WREADY;
   assign M_AXI_WVALID = in_w & s_valid;
   assign M_AXI_WDATA  = in_w ? s_data : '0;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_WLAST  = in_w & w_last;

   assign M_AXI_BREADY = bready;

endmodule

// File: tb/tb_axi4_burst_writer.sv
module tb_axi4_burst_writer;

   localparam int AW_W = 32;
   localparam int DW   = 64;
   localparam int MO   = 2;

   logic            ACLK = 1'b0;
   logic            ARESETN = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [AW_W-1:0] cmd_addr = '0;
   logic [15:0]     cmd_len = '0;
   logic [DW-1:0]   s_data = '0;
   logic            s_valid = 1'b0;
   logic            s_ready;
   logic            done, done_err, busy;
   logic [0:0]      AWID;
   logic [AW_W-1:0] AWADDR;
   logic [7:0]      AWLEN;
   logic [2:0]      AWSIZE;
   logic [1:0]      AWBURST;
   logic            AWLOCK;
   logic [3:0]      AWCACHE;
   logic [2:0]      AWPROT;
   logic [3:0]      AWQOS;
   logic            AWVALID;
   logic            AWREADY = 1'b0;
   logic [DW-1:0]   WDATA;
   logic [7:0]      WSTRB;
   logic            WLAST, WVALID;
   logic            WREADY = 1'b0;
   logic [0:0]      BID = '0;
   logic [1:0]      BRESP = '0;
   logic            BVALID = 1'b0;
   logic            BREADY;

   axi4_burst_writer #(
      .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .ID_WIDTH(1), .AXI_ID(1'b0),
      .MAX_BURST(256), .MAX_OUTSTANDING(MO), .LEN_WIDTH(16)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .done(done), .done_err(done_err), .busy(busy),
      .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
      .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE),
      .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS), .M_AXI_AWVALID(AWVALID),
      .M_AXI_AWREADY(AWREADY),
      .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WVALID(WVALID),
      .M_AXI_WREADY(WREADY),
      .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  l;
   } burst_t;

   burst_t        model_q[$];
   burst_t        exp_q[$];
   burst_t        obs_q[$];
   int            w_len_q[$];
   int            pend_b[$];
   logic [DW-1:0] dmem [0:2047];

   int  total_beats = 0, drv_idx = 0, exp_idx = 0, w_beat = 0, aw_idx = 0;
   int  out_cnt = 0, err_burst = 999, b_release = 0, dones = 0, cmd_hs_cnt = 0;
   int  cyc = 0, cmd_hs_cyc = 0, done_cyc = 0;
   int  p_aw = 100, p_w = 100, p_s = 100, p_b = 100;
   bit  b_hold = 0, exp_err = 0, active = 0, last_done_err = 0;
   bit  stall_prev = 0;
   logic [31:0] prev_addr = '0;
   logic [7:0]  prev_len = '0;

   // Burst list from the rules: cap by remaining, 256 beats and room in the 4 KB page
   function automatic void make_bursts(input logic [31:0] addr, input int len);
      logic [31:0] a;
      int rem, n, room;
      burst_t b;
      model_q.delete();
      a   = addr & ~32'h7;
      rem = len;
      while (rem > 0) begin
         room = (4096 - int'(a % 4096)) / 8;
         n = rem;
         if (n > 256) n = 256;
         if (n > room) n = room;
         b.a = a;
         b.l = 8'(n - 1);
         model_q.push_back(b);
         a   = a + 32'(n * 8);
         rem = rem - n;
      end
   endfunction

   always @(posedge ACLK) cyc++;

   // ---------------- slave / source driver ----------------
   always begin
      @(posedge ACLK);
      #1;
      AWREADY = ($urandom_range(0, 99) < p_aw);
      WREADY  = ($urandom_range(0, 99) < p_w);
      s_valid = (drv_idx < total_beats) && ($urandom_range(0, 99) < p_s);
      s_data  = (drv_idx < 2048) ? dmem[drv_idx] : '0;
      if (pend_b.size() > 0 && (!b_hold || b_release > 0) && ($urandom_range(0, 99) < p_b)) begin
         BVALID = 1'b1;
         BRESP  = (pend_b[0] == err_burst) ? 2'b10 : 2'b00;
         BID    = 1'(~pend_b[0]);
      end else begin
         BVALID = 1'b0;
         BRESP  = 2'b00;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge ACLK) begin
      burst_t e;
      bit aw_hs, w_hs, b_hs;
      if (!ARESETN) begin
         stall_prev = 0;
         chk("rst_ctrl", {AWVALID, WVALID, BREADY, cmd_ready, s_ready, done, done_err, busy}, 0);
         chk("rst_aw", {AWADDR, AWLEN}, 0);
         chk("rst_wdata", WDATA, 0);
      end else begin
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         b_hs  = BVALID && BREADY;

         if (stall_prev) begin
            chk("aw_hold_valid", AWVALID, 1);
            chk("aw_hold_addr", AWADDR, prev_addr);
            chk("aw_hold_len", AWLEN, prev_len);
         end
         stall_prev = AWVALID && !AWREADY;
         prev_addr  = AWADDR;
         prev_len   = AWLEN;

         chk("bready", BREADY, out_cnt > 0);
         chk("w_vs_s_handshake", w_hs, s_valid && s_ready);

         if (aw_hs) begin
            if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("aw_addr", AWADDR, e.a);
               chk("aw_len", AWLEN, e.l);
               chk("aw_const", {AWSIZE, AWBURST, AWCACHE, AWLOCK, AWPROT, AWQOS, AWID},
                   {3'd3, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0});
               w_len_q.push_back(int'(e.l) + 1);
               pend_b.push_back(aw_idx);
               aw_idx++;
               obs_q.push_back(e);
            end
            out_cnt++;
         end

         if (w_hs) begin
            if (w_len_q.size() == 0) chk("w_before_aw", 1, 0);
            else begin
               w_beat++;
               chk("wdata", WDATA, (exp_idx < 2048) ? dmem[exp_idx] : '0);
               chk("wlast", WLAST, w_beat == w_len_q[0]);
               chk("wstrb", WSTRB, 8'hFF);
               if (w_beat == w_len_q[0]) begin
                  void'(w_len_q.pop_front());
                  w_beat = 0;
               end
            end
            exp_idx++;
         end
         if (s_valid && s_ready) drv_idx++;

         if (b_hs) begin
            if (pend_b.size() > 0) void'(pend_b.pop_front());
            out_cnt--;
            if (b_hold && b_release > 0) b_release--;
         end
         chk("outstanding_cap", out_cnt <= MO, 1);

         if (done) begin
            chk("done_complete", {exp_q.size() == 0, w_len_q.size() == 0, out_cnt == 0,
                                  exp_idx == total_beats}, 4'b1111);
            chk("done_err", done_err, exp_err);
            chk("done_active", active, 1);
            dones++;
            done_cyc      = cyc;
            last_done_err = done_err;
         end
         chk("busy", busy, active && !done);
         chk("cmd_ready_quiet", cmd_ready && (active || done), 0);
         if (done) active = 0;
         if (cmd_valid && cmd_ready) begin
            active     = 1;
            cmd_hs_cnt++;
            cmd_hs_cyc = cyc;
         end
      end
   end

   // ---------------- main sequence ----------------
   task automatic do_reset();
      @(posedge ACLK);
      #3;
      ARESETN   = 1'b0;
      cmd_valid = 1'b0;
      exp_q.delete(); w_len_q.delete(); pend_b.delete();
      out_cnt = 0; active = 0; total_beats = 0; drv_idx = 0; exp_idx = 0; w_beat = 0;
      b_hold = 0; b_release = 0;
      repeat (3) @(negedge ACLK);
      #3;
      ARESETN = 1'b1;
   endtask

   task automatic start_cmd(input logic [31:0] addr, input int len, input int errb);
      int c0;
      bit ok;
      @(posedge ACLK);
      #1;
      make_bursts(addr, len);
      exp_q = model_q;
      obs_q.delete();
      for (int i = 0; i < len && i < 2048; i++) dmem[i] = {$urandom, $urandom};
      drv_idx = 0; exp_idx = 0; w_beat = 0; aw_idx = 0;
      total_beats = len;
      err_burst   = errb;
      exp_err     = (errb < model_q.size());
      cmd_addr    = addr;
      cmd_len     = 16'(len);
      cmd_valid   = 1'b1;
      c0 = cmd_hs_cnt;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(posedge ACLK);
         if (cmd_hs_cnt != c0) ok = 1;
      end
      #1;
      cmd_valid = 1'b0;
      if (!ok) begin
         chk("cmd_accept_timeout", 0, 1);
         do_reset();
      end
   endtask

   task automatic wait_done(input int limit);
      int d0;
      bit ok;
      d0 = dones;
      ok = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(posedge ACLK);
         if (dones != d0) ok = 1;
      end
      if (!ok) begin
         chk("done_timeout", 0, 1);
         do_reset();
      end
   endtask

   task automatic wait_obs(input int n, input int limit);
      for (int i = 0; i < limit && obs_q.size() < n; i++) @(posedge ACLK);
   endtask

   initial begin
      int d0;
      logic [31:0] ra;
      int rl;

      repeat (3) @(negedge ACLK);
      #3;
      ARESETN = 1'b1;

      // single aligned burst
      start_cmd(32'h1000, 8, 999);
      wait_done(2000);
      chk("t1_nbursts", obs_q.size(), 1);
      if (obs_q.size() == 1) chk("t1_burst", obs_q[0], {32'h1000, 8'd7});
      chk("t1_err", last_done_err, 0);

      // model pins and 4 KB split (low address bits ignored)
      make_bursts(32'h0FF0, 8);
      chk("pin_split_n", model_q.size(), 2);
      if (model_q.size() == 2) begin
         chk("pin_split_0", model_q[0], {32'h0FF0, 8'd1});
         chk("pin_split_1", model_q[1], {32'h1000, 8'd5});
      end
      start_cmd(32'h0FF5, 8, 999);
      wait_done(2000);
      chk("t2_nbursts", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("t2_b0", obs_q[0], {32'h0FF0, 8'd1});
         chk("t2_b1", obs_q[1], {32'h1000, 8'd5});
      end

      // long command: max-burst cap then page cap
      make_bursts(32'h0, 600);
      chk("pin_600_n", model_q.size(), 3);
      if (model_q.size() == 3)
         chk("pin_600", {model_q[0], model_q[1], model_q[2]},
             {32'h0, 8'd255, 32'h800, 8'd255, 32'h1000, 8'd87});
      start_cmd(32'h0, 600, 999);
      wait_done(5000);
      chk("t3_nbursts", obs_q.size(), 3);
      if (obs_q.size() == 3)
         chk("t3_bursts", {obs_q[0], obs_q[1], obs_q[2]},
             {32'h0, 8'd255, 32'h800, 8'd255, 32'h1000, 8'd87});

      // zero-length command
      start_cmd(32'h40, 0, 999);
      wait_done(100);
      chk("len0_latency", done_cyc - cmd_hs_cyc, 2);
      chk("len0_no_aw", obs_q.size(), 0);

      // credit limit with B held back
      b_hold = 1;
      b_release = 0;
      d0 = dones;
      start_cmd(32'h0, 1024, 999);
      wait_obs(2, 2000);
      repeat (40) @(posedge ACLK);
      @(negedge ACLK);
      chk("credit_aw_count", obs_q.size(), 2);
      chk("credit_awvalid_low", AWVALID, 0);
      #1;
      b_release = 1;
      wait_obs(3, 2000);
      repeat (5) @(posedge ACLK);
      chk("credit_third_aw", obs_q.size(), 3);
      chk("credit_no_done", dones, d0);
      b_hold = 0;
      wait_done(5000);
      chk("credit_total_aw", obs_q.size(), 4);

      // error on second of three bursts, then a clean command
      start_cmd(32'h0, 600, 1);
      wait_done(5000);
      chk("err_flag", last_done_err, 1);
      start_cmd(32'h2000, 16, 999);
      wait_done(2000);
      chk("err_cleared", last_done_err, 0);

      // randomized traffic with stalls and gaps
      for (int it = 0; it < 10; it++) begin
         p_aw = $urandom_range(30, 100);
         p_w  = $urandom_range(30, 100);
         p_s  = $urandom_range(30, 100);
         p_b  = $urandom_range(20, 100);
         if ($urandom_range(0, 1) == 1)
            ra = 32'h1000 * $urandom_range(1, 7) - 32'(8 * $urandom_range(1, 40)) + 32'($urandom_range(0, 7));
         else
            ra = $urandom & 32'h0000_7FFF;
         rl = $urandom_range(0, 300);
         start_cmd(ra, rl, $urandom_range(0, 5));
         wait_done(20000);
      end

      // reset in the middle of W, then a clean command
      p_aw = 80; p_w = 70; p_s = 70; p_b = 100;
      start_cmd(32'h100, 200, 999);
      for (int i = 0; i < 2000 && exp_idx < 20; i++) @(posedge ACLK);
      chk("midw_reached", exp_idx >= 20, 1);
      do_reset();
      p_aw = 100; p_w = 100; p_s = 100;
      start_cmd(32'h3000, 40, 999);
      wait_done(2000);
      chk("post_rst_nbursts", obs_q.size(), 1);
      if (obs_q.size() == 1) chk("post_rst_burst", obs_q[0], {32'h3000, 8'd39});
      chk("post_rst_err", last_done_err, 0);

      repeat (5) @(posedge ACLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
